// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared common-data-bus widths, the no-producer tag and the bus record
package cdb_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    // Tag value meaning "no producer"; a request carrying it is never broadcast.
    localparam int NO_TAG = 0;

    // One broadcast as seen by reservation stations and the register status table.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first eligible index at or after rr_ptr
module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    logic [PTR_W:0]   idx_w;
    logic [PTR_W-1:0] sel;

    // Scan offsets from farthest to nearest so the nearest eligible index is the last one written.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx_w  = '0;
        sel    = '0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            idx_w = {1'b0, rr_ptr} + (PTR_W + 1)'(off);
            if (idx_w >= (PTR_W + 1)'(NUM_SRC)) begin
                idx_w = idx_w - (PTR_W + 1)'(NUM_SRC);
            end
            sel = idx_w[PTR_W-1:0];
            if (eligible[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus broadcaster; CDB_PERF_EN adds conflict_cnt
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int DATA_W  = cdb_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
`ifdef CDB_PERF_EN
    output logic [DATA_W-1:0]         cdb_data,
    output logic [15:0]               conflict_cnt
`else
    output logic [DATA_W-1:0]         cdb_data
`endif
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] eligible;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic               found;

    // A source is masked for the cycle after its grant (src_grant is the last-grant mask),
    // because it still holds valid until the edge after it sees its own tag.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = src_valid[i]
                        && (src_tag[i*TAG_W +: TAG_W] != TAG_W'(NO_TAG))
                        && !src_grant[i];
        end
    end

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .found    (found)
    );

    // Register the winner onto the bus and advance the pointer past it; tag/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            src_grant <= '0;
            rr_ptr    <= '0;
        end else if (found) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= src_tag[int'(winner)*TAG_W +: TAG_W];
            cdb_data  <= src_data[int'(winner)*DATA_W +: DATA_W];
            src_grant <= NUM_SRC'(1) << winner;
            rr_ptr    <= (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
        end else begin
            cdb_valid <= 1'b0;
            src_grant <= '0;
        end
    end

`ifdef CDB_PERF_EN
    logic [3:0] elig_cnt;

    // Number of sources competing this cycle.
    always_comb begin
        elig_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig_cnt = elig_cnt + 4'(eligible[i]);
        end
    end

    // Saturating count of cycles where at least one eligible source lost arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if ((elig_cnt >= 4'd2) && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int NUM_SRC = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_grant;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
`ifdef CDB_PERF_EN
    logic [15:0]               conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Sources that saw their grant last cycle and drop valid at this edge.
    logic [NUM_SRC-1:0] clr_pending;

    cdb_arbiter #(
        .NUM_SRC (NUM_SRC),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_valid    (src_valid),
        .src_tag      (src_tag),
        .src_data     (src_data),
        .src_grant    (src_grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
`ifdef CDB_PERF_EN
        .cdb_data     (cdb_data),
        .conflict_cnt (conflict_cnt)
`else
        .cdb_data     (cdb_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one cycle and sample 1ns after the edge; granted sources clear valid one edge later.
    task automatic tick();
        @(posedge clk);
        #1;
        src_valid   = src_valid & ~clr_pending;
        clr_pending = src_grant;
    endtask

    task automatic set_src(input int i, input logic [3:0] tag, input logic [31:0] data);
        src_valid[i]              = 1'b1;
        src_tag[i*TAG_W +: TAG_W] = tag;
        src_data[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic expect_bc(input string name, input logic [3:0] tag, input logic [31:0] data,
                             input logic [3:0] grant);
        check_eq({name, "_valid"}, 32'(cdb_valid), 32'd1);
        check_eq({name, "_tag"},   32'(cdb_tag),   32'(tag));
        check_eq({name, "_data"},  cdb_data,       data);
        check_eq({name, "_grant"}, 32'(src_grant), 32'(grant));
    endtask

    task automatic expect_idle(input string name);
        check_eq({name, "_valid"}, 32'(cdb_valid), 32'd0);
        check_eq({name, "_grant"}, 32'(src_grant), 32'd0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        src_valid   = '0;
        src_tag     = '0;
        src_data    = '0;
        clr_pending = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        rst_n       = 1'b0;
        src_valid   = '0;
        src_tag     = '0;
        src_data    = '0;
        clr_pending = '0;
        tick();
        tick();
        check_eq("rst_valid", 32'(cdb_valid), 32'd0);
        check_eq("rst_tag",   32'(cdb_tag),   32'd0);
        check_eq("rst_data",  cdb_data,       32'd0);
        check_eq("rst_grant", 32'(src_grant), 32'd0);
`ifdef CDB_PERF_EN
        check_eq("rst_conflict", 32'(conflict_cnt), 32'd0);
`endif
        rst_n = 1'b1;

        // Single source, one broadcast, no repeat while it still holds valid
        set_src(0, 4'h3, 32'hDEAD_BEEF);
        tick(); expect_bc("single", 4'h3, 32'hDEAD_BEEF, 4'b0001);
        tick(); expect_idle("single_norepeat");
        tick(); expect_idle("single_done");

        // Four sources from reset: tags 1..4 on consecutive cycles
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 4'(i + 1), 32'hA000_0000 | 32'(i));
        tick(); expect_bc("four0", 4'h1, 32'hA000_0000, 4'b0001);
        tick(); expect_bc("four1", 4'h2, 32'hA000_0001, 4'b0010);
        tick(); expect_bc("four2", 4'h3, 32'hA000_0002, 4'b0100);
        tick(); expect_bc("four3", 4'h4, 32'hA000_0003, 4'b1000);
        tick(); expect_idle("four_end");
`ifdef CDB_PERF_EN
        check_eq("four_conflict", 32'(conflict_cnt), 32'd3);
`endif

        // Wrap after source 3: sources 0 and 2 -> 0 then 2, pointer lands on 3
        set_src(0, 4'h8, 32'hB000_0000);
        set_src(2, 4'h9, 32'hB000_0002);
        tick(); expect_bc("wrap0", 4'h8, 32'hB000_0000, 4'b0001);
        tick(); expect_bc("wrap2", 4'h9, 32'hB000_0002, 4'b0100);
        tick(); expect_idle("wrap_end");
        // Pointer at 3: source 3 beats source 0
        set_src(0, 4'hA, 32'hC000_0000);
        set_src(3, 4'hB, 32'hC000_0003);
        tick(); expect_bc("ptr3_first", 4'hB, 32'hC000_0003, 4'b1000);
        tick(); expect_bc("ptr3_second", 4'hA, 32'hC000_0000, 4'b0001);
        tick(); expect_idle("ptr3_end");

        // Back-to-back results from source 1 need a gap cycle
        do_reset();
        set_src(1, 4'h5, 32'hD000_0005);
        tick(); expect_bc("b2b_t5", 4'h5, 32'hD000_0005, 4'b0010);
        tick(); expect_idle("b2b_gap");
        set_src(1, 4'h6, 32'hD000_0006);
        tick(); expect_bc("b2b_t6", 4'h6, 32'hD000_0006, 4'b0010);
        tick(); expect_idle("b2b_end");

        // Tag 0 is never broadcast
        set_src(2, 4'h0, 32'hEEEE_EEEE);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("tag0_valid", 32'(cdb_valid), 32'd0);
        end
        src_valid[2] = 1'b0;

        // Reset during a broadcast: dropped, then re-broadcast exactly once
        set_src(0, 4'h7, 32'h7777_0007);
        tick(); expect_bc("mid_pre", 4'h7, 32'h7777_0007, 4'b0001);
        rst_n       = 1'b0;
        clr_pending = '0;
        tick();
        check_eq("mid_rst_valid", 32'(cdb_valid), 32'd0);
        check_eq("mid_rst_tag",   32'(cdb_tag),   32'd0);
        check_eq("mid_rst_data",  cdb_data,       32'd0);
        check_eq("mid_rst_grant", 32'(src_grant), 32'd0);
`ifdef CDB_PERF_EN
        check_eq("mid_rst_conflict", 32'(conflict_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick(); expect_bc("mid_post", 4'h7, 32'h7777_0007, 4'b0001);
        tick(); expect_idle("mid_once");
        tick(); expect_idle("mid_done");

        // Duplicate tags from two sources are both broadcast; pointer is at 1
        set_src(0, 4'h2, 32'hF000_0000);
        set_src(1, 4'h2, 32'hF000_0001);
        tick(); expect_bc("dup_first", 4'h2, 32'hF000_0001, 4'b0010);
        tick(); expect_bc("dup_second", 4'h2, 32'hF000_0000, 4'b0001);
        tick(); expect_idle("dup_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
